// File: rtl/alu_lookahead_seq_if.sv
// Slice-in / word-out handshake bundle for alu_lookahead_seq.
// Optional gp/gg group outputs exist only when ALU_SEQ_GROUP_PG_EN is defined.
interface alu_lookahead_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  p;
    logic [3:0]  g;
    logic        cin;
    logic        mode;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        cout;
    logic        zero;
`ifdef ALU_SEQ_GROUP_PG_EN
    logic        gp;
    logic        gg;
`endif

    modport master (
        output in_valid, p, g, cin, mode, last, out_ready,
`ifdef ALU_SEQ_GROUP_PG_EN
        input  gp, gg,
`endif
        input  in_ready, out_valid, f, cout, zero
    );

    modport slave (
        input  in_valid, p, g, cin, mode, last, out_ready,
`ifdef ALU_SEQ_GROUP_PG_EN
        output gp, gg,
`endif
        output in_ready, out_valid, f, cout, zero
    );
endinterface

// File: rtl/alu_lookahead_seq.sv
// Nibble-serial carry-lookahead assembler: folds up to four P/G slices into a 16-bit word.
// Define ALU_SEQ_GROUP_PG_EN to add word-level group propagate/generate outputs (gp, gg).
module alu_lookahead_seq (
    input  logic                 clk,
    input  logic                 rst,
    alu_lookahead_seq_if.slave   bus
);
    typedef enum logic {ACCUM, FULL} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        carry;
    logic        mode_r;
    logic [15:0] f_r;
    logic        cout_r;

    logic        first;
    logic        md;
    logic        cc;
    logic        c4;
    logic [3:0]  nib;
    logic [15:0] f_nxt;
    logic        accept;
    logic        term;

`ifdef ALU_SEQ_GROUP_PG_EN
    logic        gp_r;
    logic        gg_r;
    logic        sp;
    logic        sg;
    logic        gp_nxt;
    logic        gg_nxt;
`endif

    always_comb begin
        first  = (cnt == 2'd0);
        md     = first ? bus.mode : mode_r;
        cc     = md ? 1'b0 : (first ? bus.cin : carry);
        nib    = '0;
        for (int i = 0; i < 4; i++) begin
            nib[i] = (bus.p[i] & ~bus.g[i]) ^ cc;
            cc     = md ? 1'b0 : (bus.g[i] | (bus.p[i] & cc));
        end
        c4     = cc;
        // first slice of a word starts from a cleared word, so early-last leaves upper nibbles 0
        f_nxt  = first ? 16'h0000 : f_r;
        f_nxt[{cnt, 2'b00} +: 4] = nib;
        accept = bus.in_valid && (state == ACCUM);
        term   = bus.last || (cnt == 2'd3);
    end

`ifdef ALU_SEQ_GROUP_PG_EN
    always_comb begin
        sp = &bus.p;
        sg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sg = bus.g[i] | (bus.p[i] & sg);
        end
        gp_nxt = first ? sp : (gp_r & sp);
        gg_nxt = first ? sg : (sg | (sp & gg_r));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ACCUM;
            cnt    <= 2'd0;
            carry  <= 1'b0;
            mode_r <= 1'b0;
            f_r    <= 16'h0000;
            cout_r <= 1'b0;
`ifdef ALU_SEQ_GROUP_PG_EN
            gp_r   <= 1'b0;
            gg_r   <= 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        f_r    <= f_nxt;
                        carry  <= c4;
                        cout_r <= c4;
`ifdef ALU_SEQ_GROUP_PG_EN
                        gp_r   <= gp_nxt;
                        gg_r   <= gg_nxt;
`endif
                        if (first) begin
                            mode_r <= bus.mode;
                        end
                        if (term) begin
                            state <= FULL;
                            cnt   <= 2'd0;
                        end else begin
                            cnt   <= cnt + 2'd1;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == FULL);
    assign bus.f         = f_r;
    assign bus.cout      = cout_r;
    assign bus.zero      = (f_r == 16'h0000);
`ifdef ALU_SEQ_GROUP_PG_EN
    assign bus.gp        = gp_r;
    assign bus.gg        = gg_r;
`endif
endmodule

// File: tb/tb_alu_lookahead_seq.sv
// Bench for alu_lookahead_seq: words are described as operand pairs (a, b) and
// the expected result comes from plain integer add / xor over the accepted width.
module tb_alu_lookahead_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] held_f;

    alu_lookahead_seq_if bus();

    alu_lookahead_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic md, input int n,
                                  output logic [15:0] ef, output logic ec,
                                  output logic ez, output logic egp, output logic egg);
        int unsigned mask, am, bm, s;
        mask = (32'd1 << (4 * n)) - 32'd1;
        am   = {16'h0, a} & mask;
        bm   = {16'h0, b} & mask;
        s    = am + bm + {31'h0, ci};
        if (md) begin
            ef = 16'(am ^ bm);
            ec = 1'b0;
        end else begin
            ef = 16'(s & mask);
            ec = 1'((s >> (4 * n)) & 32'd1);
        end
        ez  = (ef == 16'h0000);
        egp = ((am | bm) == mask);
        egg = 1'(((am + bm) >> (4 * n)) & 32'd1);
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_f"},         32'(bus.f),         32'd0);
        chk({tag, "_cout"},      32'(bus.cout),      32'd0);
`ifdef ALU_SEQ_GROUP_PG_EN
        chk({tag, "_gp"},        32'(bus.gp),        32'd0);
        chk({tag, "_gg"},        32'(bus.gg),        32'd0);
`endif
    endtask

    // Feeds one word of n slices; holds out_ready low for 'hold' cycles while
    // presenting junk slices, then releases and checks the return to ACCUM.
    task automatic run_word(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic md, input int n,
                            input int hold, input int gap);
        logic [15:0] ef, pw, gw;
        logic        ec, ez, egp, egg;
        int          t;
        model(a, b, ci, md, n, ef, ec, ez, egp, egg);
        pw = a | b;
        gw = a & b;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int j = 0; j < gap; j++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.p        = 4'($urandom);
                    bus.g        = 4'($urandom);
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.p        = pw[4*k +: 4];
            bus.g        = gw[4*k +: 4];
            bus.cin      = (k == 0) ? ci : 1'($urandom);
            bus.mode     = (k == 0) ? md : 1'($urandom);
            bus.last     = (k == n - 1);
            if (k == 0) begin
                chk({tag, "_pre_f"}, 32'(bus.f), 32'(held_f));
                chk({tag, "_pre_out_valid"}, 32'(bus.out_valid), 32'd0);
            end
            t = 0;
            while (!bus.in_ready && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = (hold > 0);
        bus.p         = 4'($urandom);
        bus.g         = 4'($urandom);
        bus.last      = 1'($urandom);
        bus.out_ready = (hold == 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_in_ready_full"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_f"},    32'(bus.f),    32'(ef));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(ez));
`ifdef ALU_SEQ_GROUP_PG_EN
        chk({tag, "_gp"}, 32'(bus.gp), 32'(egp));
        chk({tag, "_gg"}, 32'(bus.gg), 32'(egg));
`endif
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_in_ready"},  32'(bus.in_ready),  32'd0);
            chk({tag, "_hold_f"},         32'(bus.f),         32'(ef));
            chk({tag, "_hold_cout"},      32'(bus.cout),      32'(ec));
            bus.p    = 4'($urandom);
            bus.g    = 4'($urandom);
            if (h == hold) begin
                bus.out_ready = 1'b1;
                bus.in_valid  = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'($urandom);
        chk({tag, "_rel_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_f"},         32'(bus.f),         32'(ef));
        held_f = ef;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.p         = 4'h0;
        bus.g         = 4'h0;
        bus.cin       = 1'b0;
        bus.mode      = 1'b0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b0;
        held_f        = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        run_word("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4, 0, 0);
        run_word("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 0, 0);
        run_word("logic_early",   16'h00FF, 16'h0001, 1'b0, 1'b1, 2, 0, 0);
        run_word("backpressure",  16'h1234, 16'h0F0F, 1'b1, 1'b0, 4, 5, 0);
        run_word("gpg_ffff_0000", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 4, 0, 1);
        run_word("gpg_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 1, 0);
        run_word("single_slice",  16'h000F, 16'h0001, 1'b1, 1'b0, 1, 0, 0);

        // reset in the middle of a word, then a full word with cin=1
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.p        = 4'hF;
            bus.g        = 4'h7;
            bus.cin      = 1'b1;
            bus.mode     = 1'b1;
            bus.last     = 1'b0;
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_state("midword_reset");
        held_f = 16'h0000;
        run_word("after_reset", 16'h8001, 16'h7FFE, 1'b1, 1'b0, 4, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_word("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_lookahead_seq.md
ALU_LOOKAHEAD_SEQ -- requirements
Module: alu_lookahead_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  slice P/G present on p/g.
REQ-004 in_ready  output  1  block accepts a slice this cycle.
REQ-005 p  input  4  per-bit propagate (a|b) from the upstream ALU slice stage.
REQ-006 g  input  4  per-bit generate (a&b) from the upstream ALU slice stage.
REQ-007 cin  input  1  word carry-in; sampled only with slice 0.
REQ-008 mode  input  1  0 = arithmetic, 1 = logic (no carries); sampled with slice 0, held for the word.
REQ-009 last  input  1  this slice ends the word.
REQ-010 out_valid  output  1  result word held on outputs.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 f  output  16  assembled result word; slice k occupies f[4k+3:4k].
REQ-013 cout  output  1  carry out of the last accepted slice.
REQ-014 zero  output  1  f == 0.

Function
REQ-015 Per slice: h_i = p_i & ~g_i; c_0 = carry register; c_{i+1} = g_i | (p_i & c_i); arithmetic f_i = h_i ^ c_i; logic f_i = h_i with all c_i forced 0.
REQ-016 Carry register loads cin on slice 0 and the slice carry-out c_4 on each later accepted slice; c_4 is forced 0 in logic mode.
REQ-017 States: ACCUM (accepting slices, slice counter 0..3) and FULL (holding result).
REQ-018 in_ready = 1 in ACCUM, 0 in FULL; out_valid = 1 only in FULL.
REQ-019 Slice accepted when in_valid & in_ready; its 4 result bits are written to the counter position the cycle after acceptance.
REQ-020 ACCUM -> FULL when the accepted slice has last=1 or the counter is 3; counter then resets to 0.
REQ-021 Early last: unwritten upper nibbles read 0; cout is c_4 of the last slice.
REQ-022 FULL -> ACCUM when out_ready=1; f, cout, zero stay stable while out_valid=1 and out_ready=0.
REQ-023 On entry to ACCUM, f is cleared to 0 on the first accepted slice of the next word, not before.
REQ-024 zero is combinational on the registered f; meaningful only while out_valid=1.
REQ-025 in_valid while in_ready=0 is ignored; no input buffering.
REQ-026 Latency: result valid one cycle after acceptance of the terminating slice; max throughput one slice per cycle, one idle cycle per word.

Reset
REQ-027 rst=1 on a clock edge: state ACCUM, counter 0, carry register 0, mode register 0, f=0, cout=0, out_valid=0.
REQ-028 rst overrides any handshake in the same cycle; a partial word in progress is discarded.

Configuration
REQ-029 With ALU_SEQ_GROUP_PG_EN defined: extra outputs gp (1) and gg (1), registered with f, giving word-level group propagate (AND of all accepted p) and group generate (lookahead over all accepted slices, cin excluded); both reset to 0.
REQ-030 Without ALU_SEQ_GROUP_PG_EN: ports gp/gg and their logic are absent; all other behaviour identical.

Verification
REQ-031 0x00FF+0x0001, cin=0, mode=0: slices (p,g)=(F,1),(F,0),(0,0),(0,0) -> f=0x0100, cout=0, zero=0, out_valid 1 cycle after 4th slice.
REQ-032 0xFFFF+0x0001, cin=0: slices (F,1),(F,0),(F,0),(F,0) -> f=0x0000, cout=1, zero=1.
REQ-033 Logic mode, slices (F,1),(F,0),last on 2nd -> f=0x00FE, cout=0; upper nibbles 0.
REQ-034 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, f/cout stable, no slice accepted; out_ready=1 -> ACCUM next cycle.
REQ-035 rst asserted after 2 of 4 slices -> all outputs reset next edge; following full word computes correctly with cin resampled.
REQ-036 With ALU_SEQ_GROUP_PG_EN: 0xFFFF+0x0000 -> gp=1, gg=0; 0xFFFF+0x0001 -> gg=1.
